// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the 9-bit core sequencer: FSM states, opcode fields
// and the load-detect helper.
package core_sequencer_pkg;

  localparam int unsigned INSTR_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EXEC,
    LWAIT,
    DONE
  } state_e;

  localparam logic [INSTR_W-1:0] kHALT = 9'h1FF;

  // Major opcode lives in Instruction[8:6]; load/store sub-op in Instruction[5:3].
  localparam logic [2:0] kRTYPE  = 3'b000;
  localparam logic [2:0] kLSTYPE = 3'b001;
  localparam logic [2:0] kEQ     = 3'b010;
  localparam logic [2:0] kLB     = 3'b000;
  localparam logic [2:0] kSB     = 3'b001;

  function automatic logic is_load(input logic [INSTR_W-1:0] instr);
    return (instr[8:6] == kLSTYPE) && (instr[5:3] == kLB);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Harness/decoder-facing signal bundle of the sequencer.
interface core_sequencer_if
  import core_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic               Start;
  logic [INSTR_W-1:0] Instruction;
  logic               BranchEn;
  logic               RegWriteEn;
  logic               MemWriteEn;
  logic               PcInit;
  logic               PcAdvance;
  logic               RegWriteQual;
  logic               MemWriteQual;
  logic               Ack;
  logic               Timeout;
  logic [CNT_W-1:0]   CycleCount;
  logic [CNT_W-1:0]   InstrCount;

  modport master (
    output Start, Instruction, BranchEn, RegWriteEn, MemWriteEn,
    input  PcInit, PcAdvance, RegWriteQual, MemWriteQual,
           Ack, Timeout, CycleCount, InstrCount
  );

  modport slave (
    input  Start, Instruction, BranchEn, RegWriteEn, MemWriteEn,
    output PcInit, PcAdvance, RegWriteQual, MemWriteQual,
           Ack, Timeout, CycleCount, InstrCount
  );
endinterface

// File: rtl/core_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: Start/Ack handshake, PC stepping, write qualification,
// load stall, cycle/retire counters and watchdog.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_WAIT  = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 0
) (
  input logic             Clk,
  input logic             Reset,
  core_sequencer_if.slave bus
);
  state_e           state_q, state_d;
  logic [2:0]       wait_q, wait_d;
  logic             ack_q, ack_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
  logic             wd_hit, wd_take, retire, cnt_clr, cyc_en;

  assign wd_hit  = (MAX_CYCLES != 0) && (cycle_cnt == CNT_W'(MAX_CYCLES));
  assign cnt_clr = (state_q == INIT);
  // The cycle that trips the watchdog is not counted, so CycleCount ends at MAX_CYCLES.
  assign cyc_en  = ((state_q == EXEC) || (state_q == LWAIT)) && !wd_hit;

  always_comb begin
    state_d          = state_q;
    wait_d           = wait_q;
    wd_take          = 1'b0;
    retire           = 1'b0;
    bus.PcInit       = 1'b0;
    bus.PcAdvance    = 1'b0;
    bus.RegWriteQual = 1'b0;
    bus.MemWriteQual = 1'b0;
    unique case (state_q)
      IDLE: if (bus.Start) state_d = INIT;
      INIT: begin
        bus.PcInit = 1'b1;
        if (!bus.Start) state_d = EXEC;
      end
      EXEC: begin
        if (bus.Start) begin
          state_d = INIT;
        end else if (wd_hit) begin
          state_d = DONE;
          wd_take = 1'b1;
        end else if (bus.Instruction == kHALT) begin
          state_d = DONE;
        end else if (is_load(bus.Instruction) && (LOAD_WAIT != 0)) begin
          state_d = LWAIT;
          wait_d  = 3'(LOAD_WAIT);
        end else begin
          retire           = 1'b1;
          bus.PcAdvance    = 1'b1;
          bus.RegWriteQual = bus.RegWriteEn;
          bus.MemWriteQual = bus.MemWriteEn;
        end
      end
      LWAIT: begin
        if (bus.Start) begin
          state_d = INIT;
          wait_d  = '0;
        end else if (wd_hit) begin
          state_d = DONE;
          wd_take = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q - 3'd1;
          if (wait_q == 3'd1) begin
            retire           = 1'b1;
            bus.PcAdvance    = 1'b1;
            bus.RegWriteQual = bus.RegWriteEn;
            state_d          = EXEC;
          end
        end
      end
      DONE: if (bus.Start) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  // Timeout survives only while DONE is held; any exit from DONE drops it.
  assign ack_d     = (state_d == DONE);
  assign timeout_d = (state_d == DONE) && (wd_take || ((state_q == DONE) && timeout_q));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clr_i   (cnt_clr),
    .en_i    (cyc_en),
    .count_o (cycle_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clr_i   (cnt_clr),
    .en_i    (retire),
    .count_o (instr_cnt)
  );

  assign bus.Ack        = ack_q;
  assign bus.Timeout    = timeout_q;
  assign bus.CycleCount = cycle_cnt;
  assign bus.InstrCount = instr_cnt;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: two instances (watchdog/long-load and narrow counters).
module tb_core_sequencer;
  import core_sequencer_pkg::*;

  localparam logic [8:0] ADD = {kRTYPE, 6'b001_010};
  localparam logic [8:0] LB  = {kLSTYPE, kLB, 3'b011};
  localparam logic [8:0] SB  = {kLSTYPE, kSB, 3'b011};

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  core_sequencer_if #(.CNT_W(16)) ifa ();
  core_sequencer_if #(.CNT_W(4))  ifb ();

  core_sequencer #(.LOAD_WAIT(2), .CNT_W(16), .MAX_CYCLES(10)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(ifa.slave)
  );
  core_sequencer #(.LOAD_WAIT(1), .CNT_W(4), .MAX_CYCLES(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(ifb.slave)
  );

  typedef struct {
    string      tag;
    logic [3:0] ex;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          use_b = 1'b0;

  // Expected {PcInit, PcAdvance, RegWriteQual, MemWriteQual} queued with the stimulus.
  task automatic drive(input logic st, input logic [8:0] ins, input logic rw, input logic mw,
                       input logic [3:0] ex, input string tag);
    if (use_b) begin
      ifb.Start = st; ifb.Instruction = ins; ifb.RegWriteEn = rw; ifb.MemWriteEn = mw;
      ifb.BranchEn = 1'b0;
    end else begin
      ifa.Start = st; ifa.Instruction = ins; ifa.RegWriteEn = rw; ifa.MemWriteEn = mw;
      ifa.BranchEn = 1'b0;
    end
    sb.push_back('{tag: tag, ex: ex});
  endtask

  task automatic observe();
    exp_t       e;
    logic [3:0] o;
    e = sb.pop_front();
    o = use_b ? {ifb.PcInit, ifb.PcAdvance, ifb.RegWriteQual, ifb.MemWriteQual}
              : {ifa.PcInit, ifa.PcAdvance, ifa.RegWriteQual, ifa.MemWriteQual};
    n_cmp++;
    assert (o === e.ex) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", e.tag, o, e.ex);
    end
  endtask

  task automatic step(input logic st, input logic [8:0] ins, input logic rw, input logic mw,
                      input logic [3:0] ex, input string tag);
    drive(st, ins, rw, mw, ex, tag);
    #2;
    observe();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  initial begin
    ifa.Start = 1'b0; ifa.Instruction = '0; ifa.BranchEn = 1'b0;
    ifa.RegWriteEn = 1'b0; ifa.MemWriteEn = 1'b0;
    ifb.Start = 1'b0; ifb.Instruction = '0; ifb.BranchEn = 1'b0;
    ifb.RegWriteEn = 1'b0; ifb.MemWriteEn = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // Reset state
    chk("rst_ack",   16'(ifa.Ack), 16'd0);
    chk("rst_tmo",   16'(ifa.Timeout), 16'd0);
    chk("rst_cyc",   ifa.CycleCount, 16'd0);
    chk("rst_instr", ifa.InstrCount, 16'd0);
    chk("rst_b_ack", 16'(ifb.Ack), 16'd0);
    step(1'b0, ADD, 1'b1, 1'b1, 4'b0000, "idle_comb");

    // Start for 3 cycles, 4 adds, halt
    step(1'b1, ADD, 1'b0, 1'b0, 4'b0000, "t1_idle_start");
    step(1'b1, ADD, 1'b0, 1'b0, 4'b1000, "t1_init1");
    step(1'b1, ADD, 1'b0, 1'b0, 4'b1000, "t1_init2");
    step(1'b0, ADD, 1'b0, 1'b0, 4'b1000, "t1_init3");
    for (int i = 0; i < 4; i++) step(1'b0, ADD, 1'b1, 1'b0, 4'b0110, "t1_add");
    step(1'b0, kHALT, 1'b1, 1'b1, 4'b0000, "t1_halt");
    chk("t1_ack",   16'(ifa.Ack), 16'd1);
    chk("t1_tmo",   16'(ifa.Timeout), 16'd0);
    chk("t1_instr", ifa.InstrCount, 16'd4);
    chk("t1_cyc",   ifa.CycleCount, 16'd5);
    step(1'b0, ADD, 1'b1, 1'b1, 4'b0000, "t1_done_comb");
    chk("t1_ack_hold", 16'(ifa.Ack), 16'd1);

    // Load (LOAD_WAIT=2), store, halt
    step(1'b1, ADD, 1'b0, 1'b0, 4'b0000, "t2_done_start");
    chk("t2_ack_fall", 16'(ifa.Ack), 16'd0);
    step(1'b0, ADD, 1'b0, 1'b0, 4'b1000, "t2_init");
    chk("t2_cyc_clr", ifa.CycleCount, 16'd0);
    chk("t2_instr_clr", ifa.InstrCount, 16'd0);
    step(1'b0, LB, 1'b1, 1'b0, 4'b0000, "t2_lb_exec");
    step(1'b0, LB, 1'b1, 1'b1, 4'b0000, "t2_lwait1");
    step(1'b0, LB, 1'b1, 1'b1, 4'b0110, "t2_lwait2");
    step(1'b0, SB, 1'b0, 1'b1, 4'b0101, "t2_sb");
    step(1'b0, kHALT, 1'b0, 1'b0, 4'b0000, "t2_halt");
    chk("t2_ack",   16'(ifa.Ack), 16'd1);
    chk("t2_instr", ifa.InstrCount, 16'd2);
    chk("t2_cyc",   ifa.CycleCount, 16'd5);

    // Start during a store in EXEC
    step(1'b1, ADD, 1'b0, 1'b0, 4'b0000, "t3_done_start");
    step(1'b0, ADD, 1'b0, 1'b0, 4'b1000, "t3_init");
    step(1'b0, ADD, 1'b1, 1'b0, 4'b0110, "t3_add");
    step(1'b1, SB, 1'b0, 1'b1, 4'b0000, "t3_sb_abort");
    step(1'b0, ADD, 1'b0, 1'b0, 4'b1000, "t3_back_init");
    chk("t3_cyc_clr",   ifa.CycleCount, 16'd0);
    chk("t3_instr_clr", ifa.InstrCount, 16'd0);
    chk("t3_ack",       16'(ifa.Ack), 16'd0);

    // Watchdog at MAX_CYCLES=10
    for (int i = 0; i < 10; i++) step(1'b0, ADD, 1'b1, 1'b0, 4'b0110, "t4_add");
    step(1'b0, SB, 1'b1, 1'b1, 4'b0000, "t4_wd_final");
    chk("t4_tmo",   16'(ifa.Timeout), 16'd1);
    chk("t4_ack",   16'(ifa.Ack), 16'd1);
    chk("t4_cyc",   ifa.CycleCount, 16'd10);
    chk("t4_instr", ifa.InstrCount, 16'd10);
    step(1'b1, ADD, 1'b0, 1'b0, 4'b0000, "t4_done_start");
    chk("t4_tmo_fall", 16'(ifa.Timeout), 16'd0);
    chk("t4_ack_fall", 16'(ifa.Ack), 16'd0);

    // Reset in the middle of a load stall
    step(1'b0, ADD, 1'b0, 1'b0, 4'b1000, "t5_init");
    step(1'b0, LB, 1'b1, 1'b0, 4'b0000, "t5_lb_exec");
    chk("t5_cyc_pre", ifa.CycleCount, 16'd1);
    drive(1'b0, LB, 1'b1, 1'b1, 4'b0000, "t5_rst_comb");
    #1 Reset = 1'b1;
    #1 observe();
    chk("t5_state", 16'(dut_a.state_q), 16'(IDLE));
    chk("t5_cyc",   ifa.CycleCount, 16'd0);
    chk("t5_instr", ifa.InstrCount, 16'd0);
    chk("t5_ack",   16'(ifa.Ack), 16'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    step(1'b0, LB, 1'b1, 1'b1, 4'b0000, "t5_idle");
    step(1'b1, ADD, 1'b0, 1'b0, 4'b0000, "t5_start");
    step(1'b0, ADD, 1'b0, 1'b0, 4'b1000, "t5_init2");
    step(1'b0, kHALT, 1'b0, 1'b0, 4'b0000, "t5_halt");
    chk("t5_ack2",   16'(ifa.Ack), 16'd1);
    chk("t5_instr2", ifa.InstrCount, 16'd0);
    chk("t5_cyc2",   ifa.CycleCount, 16'd1);

    // Narrow counters saturate (CNT_W=4, LOAD_WAIT=1)
    use_b = 1'b1;
    step(1'b1, ADD, 1'b0, 1'b0, 4'b0000, "t6_start");
    step(1'b0, ADD, 1'b0, 1'b0, 4'b1000, "t6_init");
    step(1'b0, LB, 1'b1, 1'b0, 4'b0000, "t6_lb_exec");
    step(1'b0, LB, 1'b1, 1'b1, 4'b0110, "t6_lwait");
    for (int i = 0; i < 19; i++) step(1'b0, ADD, 1'b1, 1'b0, 4'b0110, "t6_add");
    step(1'b0, kHALT, 1'b0, 1'b0, 4'b0000, "t6_halt");
    chk("t6_ack",   16'(ifb.Ack), 16'd1);
    chk("t6_instr", 16'(ifb.InstrCount), 16'd15);
    chk("t6_cyc",   16'(ifb.CycleCount), 16'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
